// File: rtl/game_pkg.sv
// Shared game constants: state encodings used by the access and load-control blocks.
package game_pkg;
  localparam int STATE_W   = 3;
  localparam int DEF_VAL_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_HAVE1 = 3'd1;
  localparam logic [STATE_W-1:0] S_HAVE2 = 3'd2;
  localparam logic [STATE_W-1:0] S_READY = 3'd3;
  localparam logic [STATE_W-1:0] S_RUN   = 3'd4;

  function automatic logic is_load_state(input logic [STATE_W-1:0] st);
    return (st == S_IDLE) || (st == S_HAVE1) || (st == S_HAVE2);
  endfunction
endpackage

// File: rtl/load_timeout_cnt.sv
// Wait-for-second-player counter; expire flags the last cycle of the window.
module load_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) r_cnt <= '0;
    else if (en)    r_cnt <= r_cnt + 1'b1;
  end

  assign expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/player_load_ctrl.sv
// Captures one secret value per player, times out a missing second load,
// and hands the pair to the game core under a ready/ack handshake.
module player_load_ctrl
  import game_pkg::*;
#(
  parameter int VAL_W       = DEF_VAL_W,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load1_in,
  input  logic               load2_in,
  input  logic               access_ok,
  input  logic [VAL_W-1:0]   num_in,
  input  logic               start_ack,
  input  logic               game_done,
  output logic [VAL_W-1:0]   p1_val,
  output logic [VAL_W-1:0]   p2_val,
  output logic               p1_loaded,
  output logic               p2_loaded,
  output logic               ready,
  output logic               running,
  output logic               timeout_err,
  output logic [STATE_W-1:0] state_ld
);
  logic [STATE_W-1:0] r_state;
  logic [VAL_W-1:0]   r_p1_val, r_p2_val;
  logic               r_p1_loaded, r_p2_loaded;
  logic               r_ready, r_running, r_timeout_err;

  logic               w_acc1, w_acc2, w_any, w_in_wait;
  logic               w_l1n, w_l2n, w_both, w_expire;
  logic [STATE_W-1:0] w_nxt_have;

  always_comb begin
    w_acc1     = load1_in & access_ok & is_load_state(r_state);
    w_acc2     = load2_in & access_ok & is_load_state(r_state);
    w_any      = w_acc1 | w_acc2;
    w_in_wait  = (r_state == S_HAVE1) || (r_state == S_HAVE2);
    w_l1n      = r_p1_loaded | w_acc1;
    w_l2n      = r_p2_loaded | w_acc2;
    w_both     = w_l1n & w_l2n;
    w_nxt_have = w_both ? S_READY : (w_l1n ? S_HAVE1 : S_HAVE2);
  end

  // Any accepted load restarts the window; outside the wait states it is held at zero.
  load_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr   (~w_in_wait | w_any | w_expire),
    .en    (w_in_wait & ~w_any),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_p1_val      <= '0;
      r_p2_val      <= '0;
      r_p1_loaded   <= 1'b0;
      r_p2_loaded   <= 1'b0;
      r_ready       <= 1'b0;
      r_running     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE, S_HAVE1, S_HAVE2: begin
          if (w_acc1) begin
            r_p1_val    <= num_in;
            r_p1_loaded <= 1'b1;
          end
          if (w_acc2) begin
            r_p2_val    <= num_in;
            r_p2_loaded <= 1'b1;
          end
          // A load landing in the expiry cycle takes priority over the timeout.
          if (w_any) begin
            r_state <= w_nxt_have;
            r_ready <= w_both;
          end else if (w_in_wait && w_expire) begin
            r_state       <= S_IDLE;
            r_p1_val      <= '0;
            r_p2_val      <= '0;
            r_p1_loaded   <= 1'b0;
            r_p2_loaded   <= 1'b0;
            r_timeout_err <= 1'b1;
          end
        end
        S_READY: begin
          if (start_ack) begin
            r_ready   <= 1'b0;
            r_running <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (game_done) begin
            r_state     <= S_IDLE;
            r_p1_val    <= '0;
            r_p2_val    <= '0;
            r_p1_loaded <= 1'b0;
            r_p2_loaded <= 1'b0;
            r_running   <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_p1_val    <= '0;
          r_p2_val    <= '0;
          r_p1_loaded <= 1'b0;
          r_p2_loaded <= 1'b0;
          r_ready     <= 1'b0;
          r_running   <= 1'b0;
        end
      endcase
    end
  end

  assign p1_val      = r_p1_val;
  assign p2_val      = r_p2_val;
  assign p1_loaded   = r_p1_loaded;
  assign p2_loaded   = r_p2_loaded;
  assign ready       = r_ready;
  assign running     = r_running;
  assign timeout_err = r_timeout_err;
  assign state_ld    = r_state;
endmodule

// File: tb/tb_player_load_ctrl.sv
// Bench for player_load_ctrl: directed vector table, timing sequences, random vs model.
module tb_player_load_ctrl;
  localparam int VW = 4;
  localparam int T  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1, load1_in = 1'b0, load2_in = 1'b0, access_ok = 1'b0;
  logic [VW-1:0] num_in = '0;
  logic          start_ack = 1'b0, game_done = 1'b0;
  logic [VW-1:0] p1_val, p2_val;
  logic          p1_loaded, p2_loaded, ready, running, timeout_err;
  logic [2:0]    state_ld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  player_load_ctrl #(.VAL_W(VW), .TIMEOUT_CYC(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .load1_in(load1_in), .load2_in(load2_in),
    .access_ok(access_ok), .num_in(num_in), .start_ack(start_ack),
    .game_done(game_done), .p1_val(p1_val), .p2_val(p2_val),
    .p1_loaded(p1_loaded), .p2_loaded(p2_loaded), .ready(ready),
    .running(running), .timeout_err(timeout_err), .state_ld(state_ld)
  );

  typedef struct {
    logic          r, l1, l2, ok, ack, dn;
    logic [VW-1:0] n;
    logic [VW-1:0] e_p1, e_p2;
    logic          e_l1, e_l2, e_rdy, e_run, e_to;
    logic [2:0]    e_st;
  } vec_t;

  task automatic drive(input logic r, l1, l2, ok, ack, dn, input logic [VW-1:0] n);
    @(negedge clk);
    rst = r; load1_in = l1; load2_in = l2; access_ok = ok;
    start_ack = ack; game_done = dn; num_in = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_out(input string nm, input logic [VW-1:0] ep1, ep2,
                            input logic el1, el2, erdy, erun, eto, input logic [2:0] est);
    total++;
    if ({p1_val, p2_val, p1_loaded, p2_loaded, ready, running, timeout_err, state_ld} !==
        {ep1, ep2, el1, el2, erdy, erun, eto, est}) begin
      bad++;
      $display("FAIL %s: got p1=%0d p2=%0d ld=%b%b rdy=%b run=%b to=%b st=%0d, want p1=%0d p2=%0d ld=%b%b rdy=%b run=%b to=%b st=%0d",
               nm, p1_val, p2_val, p1_loaded, p2_loaded, ready, running, timeout_err, state_ld,
               ep1, ep2, el1, el2, erdy, erun, eto, est);
    end
  endtask

  // Reference model: phase 0 = collecting loads, 1 = pair offered, 2 = round running.
  logic [VW-1:0] m_p1, m_p2;
  logic          m_l1, m_l2, m_to;
  int            m_ph, m_wait;

  task automatic m_clear();
    m_p1 = '0; m_p2 = '0; m_l1 = 1'b0; m_l2 = 1'b0; m_wait = 0;
  endtask

  task automatic model_step(input logic r, l1, l2, ok, ack, dn, input logic [VW-1:0] n);
    logic a1, a2;
    m_to = 1'b0;
    if (r) begin
      m_clear(); m_ph = 0;
    end else if (m_ph == 0) begin
      a1 = l1 & ok; a2 = l2 & ok;
      if (a1) begin m_p1 = n; m_l1 = 1'b1; end
      if (a2) begin m_p2 = n; m_l2 = 1'b1; end
      if (a1 || a2) m_wait = 0;
      else if (m_l1 != m_l2) begin
        m_wait++;
        if (m_wait == T) begin m_clear(); m_to = 1'b1; end
      end
      if (m_l1 && m_l2) m_ph = 1;
    end else if (m_ph == 1) begin
      if (ack) m_ph = 2;
    end else if (dn) begin
      m_clear(); m_ph = 0;
    end
  endtask

  function automatic logic [2:0] m_state();
    if (m_ph == 1) return 3'd3;
    if (m_ph == 2) return 3'd4;
    if (m_l1) return 3'd1;
    if (m_l2) return 3'd2;
    return 3'd0;
  endfunction

  vec_t vt[14];

  initial begin
    //        r   l1  l2  ok  ack dn  n      p1 p2 l1 l2 rdy run to st
    vt[0]  = '{1, 0, 0, 0, 0, 0, 4'd0,  4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0};
    vt[1]  = '{0, 1, 0, 0, 0, 0, 4'd7,  4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0};
    vt[2]  = '{0, 1, 0, 1, 0, 0, 4'd3,  4'd3, 4'd0, 1, 0, 0, 0, 0, 3'd1};
    vt[3]  = '{0, 0, 0, 1, 0, 0, 4'd0,  4'd3, 4'd0, 1, 0, 0, 0, 0, 3'd1};
    vt[4]  = '{0, 0, 1, 1, 0, 0, 4'd5,  4'd3, 4'd5, 1, 1, 1, 0, 0, 3'd3};
    vt[5]  = '{0, 1, 0, 1, 0, 0, 4'd9,  4'd3, 4'd5, 1, 1, 1, 0, 0, 3'd3};
    vt[6]  = '{0, 0, 0, 1, 1, 0, 4'd0,  4'd3, 4'd5, 1, 1, 0, 1, 0, 3'd4};
    vt[7]  = '{0, 1, 0, 1, 0, 0, 4'd9,  4'd3, 4'd5, 1, 1, 0, 1, 0, 3'd4};
    vt[8]  = '{0, 0, 0, 1, 1, 0, 4'd0,  4'd3, 4'd5, 1, 1, 0, 1, 0, 3'd4};
    vt[9]  = '{0, 0, 0, 1, 0, 1, 4'd0,  4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0};
    vt[10] = '{0, 1, 1, 1, 0, 0, 4'd10, 4'd10, 4'd10, 1, 1, 1, 0, 0, 3'd3};
    vt[11] = '{1, 0, 0, 1, 0, 0, 4'd0,  4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0};
    vt[12] = '{0, 0, 0, 1, 1, 0, 4'd0,  4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0};
    vt[13] = '{0, 0, 0, 1, 0, 1, 4'd0,  4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0};

    drive(1'b1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].r, vt[i].l1, vt[i].l2, vt[i].ok, vt[i].ack, vt[i].dn, vt[i].n);
      expect_out($sformatf("vec%0d", i), vt[i].e_p1, vt[i].e_p2, vt[i].e_l1, vt[i].e_l2,
                 vt[i].e_rdy, vt[i].e_run, vt[i].e_to, vt[i].e_st);
    end

    // Player 2 loads alone and the window runs out.
    drive(0, 0, 1, 1, 0, 0, 4'd4);
    expect_out("to_load", 4'd0, 4'd4, 0, 1, 0, 0, 0, 3'd2);
    for (int k = 1; k < T; k++) begin
      idle();
      expect_out($sformatf("to_wait%0d", k), 4'd0, 4'd4, 0, 1, 0, 0, 0, 3'd2);
    end
    idle();
    expect_out("to_fire", 4'd0, 4'd0, 0, 0, 0, 0, 1, 3'd0);
    idle();
    expect_out("to_once", 4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0);

    // Reload of player 1 restarts the window.
    drive(0, 1, 0, 1, 0, 0, 4'd2);
    for (int c = 1; c < 6; c++) begin
      idle();
      expect_out($sformatf("rs_a%0d", c), 4'd2, 4'd0, 1, 0, 0, 0, 0, 3'd1);
    end
    drive(0, 1, 0, 1, 0, 0, 4'd6);
    for (int c = 7; c < 13; c++) begin
      idle();
      expect_out($sformatf("rs_b%0d", c), 4'd6, 4'd0, 1, 0, 0, 0, 0, 3'd1);
    end
    drive(0, 0, 1, 1, 0, 0, 4'd1);
    expect_out("rs_rdy", 4'd6, 4'd1, 1, 1, 1, 0, 0, 3'd3);
    drive(0, 0, 0, 1, 1, 0, '0);
    drive(0, 0, 0, 1, 0, 1, '0);
    expect_out("rs_clr", 4'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0);

    // A load in the expiry cycle beats the timeout, then the full window elapses.
    drive(0, 1, 0, 1, 0, 0, 4'd2);
    for (int k = 1; k < T; k++) idle();
    drive(0, 1, 0, 1, 0, 0, 4'd6);
    expect_out("exp_win", 4'd6, 4'd0, 1, 0, 0, 0, 0, 3'd1);
    for (int k = 1; k < T; k++) idle();
    expect_out("exp_pre", 4'd6, 4'd0, 1, 0, 0, 0, 0, 3'd1);
    idle();
    expect_out("exp_fire", 4'd0, 4'd0, 0, 0, 0, 0, 1, 3'd0);

    // Random traffic against the model.
    drive(1'b1, 0, 0, 0, 0, 0, '0);
    m_clear(); m_ph = 0; m_to = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic r, l1, l2, ok, ack, dn;
      logic [VW-1:0] n;
      r   = ($urandom_range(0, 299) == 0);
      l1  = ($urandom_range(0, 11) == 0);
      l2  = ($urandom_range(0, 11) == 0);
      ok  = ($urandom_range(0, 7) != 0);
      ack = ($urandom_range(0, 3) == 0);
      dn  = ($urandom_range(0, 5) == 0);
      n   = VW'($urandom_range(0, 15));
      drive(r, l1, l2, ok, ack, dn, n);
      model_step(r, l1, l2, ok, ack, dn, n);
      expect_out("rand", m_p1, m_p2, m_l1, m_l2, m_ph == 1, m_ph == 2, m_to, m_state());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
